// File: rtl/fir_pkg.sv
// Shared sizing constants and FSM encoding for the pulse-shaping FIR.
// Modules take their parameter defaults from here.
package fir_pkg;
    localparam int NTAPS = 65;
    localparam int DW    = 16;
    localparam int FRAC  = 13;
    localparam int ACCW  = 40;
    localparam int CAW   = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } fir_state_e;
endpackage

// File: rtl/pulse_shape_fir_if.sv
// Sample/coefficient/result bundle of the pulse-shaping FIR.
// The slave side is the filter; the master side is the sample and coefficient source and result sink.
interface pulse_shape_fir_if #(
    parameter int DW  = fir_pkg::DW,
    parameter int CAW = fir_pkg::CAW
);
    logic [DW-1:0]  sample_in;
    logic           sample_valid;
    logic           ready;
    logic [CAW-1:0] coef_addr;
    logic [DW-1:0]  coef_in;
    logic [DW-1:0]  y_out;
    logic           y_valid;
    logic           sample_drop;

    modport slave (
        input  sample_in, sample_valid, coef_in,
        output ready, coef_addr, y_out, y_valid, sample_drop
    );

    modport master (
        output sample_in, sample_valid, coef_in,
        input  ready, coef_addr, y_out, y_valid, sample_drop
    );
endinterface

// File: rtl/fir_sample_line.sv
// Circular NTAPS-entry sample history: one write port, one combinational read-by-age port.
// Write takes effect on the clock edge; rd_off=0 returns the newest written sample.
module fir_sample_line
    import fir_pkg::*;
#(
    parameter int NTAPS = fir_pkg::NTAPS,
    parameter int DW    = fir_pkg::DW,
    parameter int CAW   = fir_pkg::CAW
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           wr_en,
    input  logic [DW-1:0]  wr_dat,
    input  logic [CAW-1:0] rd_off,
    output logic [DW-1:0]  rd_dat
);
    localparam logic [CAW-1:0] LAST  = CAW'(NTAPS - 1);
    localparam logic [CAW-1:0] DEPTH = CAW'(NTAPS);

    logic [CAW-1:0] wr_ptr_q, wr_ptr_d;
    logic [DW-1:0]  mem_q [NTAPS];
    logic [DW-1:0]  mem_d [NTAPS];
    logic [CAW-1:0] newest;
    logic [CAW-1:0] rd_idx;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = wr_dat;
            wr_ptr_d        = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        // The pointer has already moved past the newest entry, so age 0 sits one slot behind it.
        newest = (wr_ptr_q == '0) ? LAST : wr_ptr_q - 1'b1;
        rd_idx = (newest >= rd_off) ? newest - rd_off : newest - rd_off + DEPTH;
        rd_dat = mem_q[rd_idx];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            for (int i = 0; i < NTAPS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// File: rtl/pulse_shape_fir.sv
// Pulse-shaping FIR with one shared multiplier; y_valid pulses NTAPS+2 cycles after a sample is taken.
// ready is high only while idle; samples offered while busy are discarded and flagged on sample_drop.
module pulse_shape_fir #(
    parameter int NTAPS = fir_pkg::NTAPS,
    parameter int DW    = fir_pkg::DW,
    parameter int ACCW  = fir_pkg::ACCW
) (
    input  logic               clk,
    input  logic               reset_n,
    pulse_shape_fir_if.slave   bus
);
    import fir_pkg::*;

    localparam int PW = 2 * DW;
    localparam logic [CAW-1:0]         LAST_TAP = CAW'(NTAPS - 1);
    localparam logic signed [ACCW-1:0] RND_BIAS = {{(ACCW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    localparam logic signed [ACCW-1:0] YMAX     = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] YMIN     = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    fir_state_e             state_q, state_d;
    logic [CAW-1:0]         tap_q, tap_d;
    logic                   ready_q, ready_d;
    logic                   y_vld_q, y_vld_d;
    logic                   drop_q, drop_d;
    logic [DW-1:0]          y_q, y_d;
    logic signed [PW-1:0]   prod_q, prod_d;
    logic                   prod_vld_q, prod_vld_d;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic signed [ACCW-1:0] acc_sum, rnd_sh;
    logic [DW-1:0]          y_sat;
    logic [DW-1:0]          x_rd;
    logic                   accept;

    assign accept           = bus.sample_valid && (state_q == ST_IDLE);
    assign bus.ready        = ready_q;
    assign bus.coef_addr    = tap_q;
    assign bus.y_out        = y_q;
    assign bus.y_valid      = y_vld_q;
    assign bus.sample_drop  = drop_q;

    fir_sample_line #(
        .NTAPS (NTAPS),
        .DW    (DW),
        .CAW   (CAW)
    ) u_line (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (accept),
        .wr_dat  (bus.sample_in),
        .rd_off  (tap_q),
        .rd_dat  (x_rd)
    );

    always_comb begin
        prod_d     = PW'($signed(x_rd)) * PW'($signed(bus.coef_in));
        prod_vld_d = (state_q == ST_MAC);
        acc_sum    = acc_q + ACCW'(prod_q);
        acc_d      = acc_q;
        if (accept) begin
            acc_d = '0;
        end else if (prod_vld_q) begin
            acc_d = acc_sum;
        end

        // In DRAIN acc_sum already includes the last tap, so the result is taken from it directly.
        rnd_sh = (acc_sum + RND_BIAS) >>> FRAC;
        if (rnd_sh > YMAX) begin
            y_sat = {1'b0, {(DW-1){1'b1}}};
        end else if (rnd_sh < YMIN) begin
            y_sat = {1'b1, {(DW-1){1'b0}}};
        end else begin
            y_sat = rnd_sh[DW-1:0];
        end

        state_d = state_q;
        tap_d   = tap_q;
        y_d     = y_q;
        y_vld_d = 1'b0;
        drop_d  = bus.sample_valid && (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_MAC;
                    tap_d   = '0;
                end
            end
            ST_MAC: begin
                if (tap_q == LAST_TAP) begin
                    state_d = ST_DRAIN;
                    tap_d   = '0;
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                state_d = ST_OUT;
                y_d     = y_sat;
                y_vld_d = 1'b1;
            end
            ST_OUT:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            tap_q      <= '0;
            ready_q    <= 1'b1;
            y_vld_q    <= 1'b0;
            drop_q     <= 1'b0;
            y_q        <= '0;
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
        end else begin
            state_q    <= state_d;
            tap_q      <= tap_d;
            ready_q    <= ready_d;
            y_vld_q    <= y_vld_d;
            drop_q     <= drop_d;
            y_q        <= y_d;
            prod_q     <= prod_d;
            prod_vld_q <= prod_vld_d;
            acc_q      <= acc_d;
        end
    end
endmodule

// File: tb/tb_pulse_shape_fir.sv
// Directed vector table plus hand-written reset, drop and wrap-around sequences for pulse_shape_fir.
module tb_pulse_shape_fir;
    import fir_pkg::*;

    typedef struct {
        int          cset;
        logic [15:0] smp;
        bit          has_exp;
        logic [15:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    pulse_shape_fir_if #(.DW(16), .CAW(7)) bus_if ();

    pulse_shape_fir dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    logic [15:0]        coef_tab [0:127];
    logic [15:0]        team_tab [0:127];
    logic signed [15:0] hist     [0:NTAPS-1];
    logic [15:0]        imp      [0:NTAPS-1];
    logic [15:0]        last_y;
    vec_t               vecs [$];
    int                 n_vec = 0;
    int                 n_err = 0;

    assign bus_if.coef_in = coef_tab[bus_if.coef_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add_vec(int cs, logic [15:0] smp, bit he, logic [15:0] ex);
        vec_t v;
        v.cset = cs; v.smp = smp; v.has_exp = he; v.exp = ex;
        vecs.push_back(v);
    endfunction

    task automatic set_coefs(input int cset);
        for (int k = 0; k < 128; k++) begin
            case (cset)
                0:       coef_tab[k] = team_tab[k];
                1:       coef_tab[k] = (k == 0) ? 16'h1000 : 16'h0000;
                default: coef_tab[k] = (k < NTAPS) ? 16'h7FFF : 16'h0000;
            endcase
        end
    endtask

    task automatic clear_hist();
        for (int k = 0; k < NTAPS; k++) hist[k] = '0;
        last_y = '0;
    endtask

    function automatic logic [15:0] model_y();
        longint acc;
        acc = 0;
        for (int k = 0; k < NTAPS; k++)
            acc += longint'($signed(coef_tab[k])) * longint'(hist[k]);
        acc = (acc + 4096) >>> 13;
        if (acc > 32767)  return 16'h7FFF;
        if (acc < -32768) return 16'h8000;
        return acc[15:0];
    endfunction

    // Offers one sample (from a negedge) and follows it to its result.
    task automatic send(input logic [15:0] s, input int drop_at, output logic [15:0] y);
        int          cnt;
        int          drops;
        bit          hold_bad;
        logic [15:0] exp;
        cnt = 0;
        while (!bus_if.ready && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        chk("ready_before_send", bus_if.ready, 1);
        bus_if.sample_in    = s;
        bus_if.sample_valid = 1'b1;
        @(posedge clk);
        for (int k = NTAPS - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = s;
        exp = model_y();
        @(negedge clk);
        bus_if.sample_valid = 1'b0;
        bus_if.sample_in    = 16'hDEAD;
        chk("ready_busy", bus_if.ready, 0);
        cnt = 1;
        drops = 0;
        hold_bad = 1'b0;
        while (!bus_if.y_valid && cnt < 200) begin
            if (bus_if.y_out !== last_y) hold_bad = 1'b1;
            if (cnt == 5) chk("coef_addr_tap4", bus_if.coef_addr, 4);
            bus_if.sample_valid = (cnt == drop_at);
            bus_if.sample_in    = 16'h5A5A;
            @(negedge clk);
            cnt++;
            if (bus_if.sample_drop) drops++;
        end
        bus_if.sample_valid = 1'b0;
        chk("latency", cnt, 67);
        chk("y_hold", hold_bad, 0);
        y = bus_if.y_out;
        chk("model", y, exp);
        chk("drop_pulses", drops, (drop_at > 0) ? 1 : 0);
        last_y = y;
        @(negedge clk);
        chk("y_valid_one_cycle", bus_if.y_valid, 0);
        chk("ready_idle", bus_if.ready, 1);
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] y;
        int          nv;

        for (int k = 0; k < 128; k++) begin
            int d, v;
            d = (k < 32) ? 32 - k : k - 32;
            if (k >= NTAPS)  v = 0;
            else if (d == 0)  v = 4320;
            else if (d == 1)  v = 3831;
            else if (d == 31) v = 13;
            else if (d == 32) v = -5;
            else begin
                v = 12000 / (d * d + 2);
                if ((d % 4) >= 2) v = -v;
            end
            team_tab[k] = 16'(v);
        end

        for (int k = 0; k < NTAPS; k++) add_vec(0, (k == 0) ? 16'h2000 : 16'h0000, 1'b1, team_tab[k]);
        add_vec(1, 16'h0001, 1'b1, 16'h0001);
        add_vec(1, 16'hFFFF, 1'b1, 16'h0000);
        for (int k = 0; k < NTAPS; k++) add_vec(2, 16'h7FFF, k == NTAPS - 1, 16'h7FFF);
        for (int k = 0; k < NTAPS; k++) add_vec(2, 16'h8000, k == NTAPS - 1, 16'h8000);

        reset_n             = 1'b0;
        bus_if.sample_valid = 1'b0;
        bus_if.sample_in    = '0;
        set_coefs(0);
        clear_hist();
        repeat (3) @(negedge clk);
        chk("rst_ready", bus_if.ready, 1);
        chk("rst_y_valid", bus_if.y_valid, 0);
        chk("rst_y_out", bus_if.y_out, 0);
        chk("rst_drop", bus_if.sample_drop, 0);
        chk("rst_coef_addr", bus_if.coef_addr, 0);
        reset_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            set_coefs(vecs[i].cset);
            send(vecs[i].smp, 0, y);
            if (i < NTAPS) imp[i] = y;
            if (vecs[i].has_exp) chk($sformatf("vec%0d", i), y, vecs[i].exp);
        end
        chk("impulse_out2", imp[1], 16'h000D);
        chk("impulse_out33", imp[32], 16'h10E0);
        chk("impulse_out34", imp[33], 16'h0EF7);

        // A sample offered mid-computation must leave no trace in the result stream.
        set_coefs(0);
        send(16'h1234, 10, y);
        send(16'hE000, 0, y);

        for (int i = 0; i < 200; i++) send(16'($urandom), 0, y);

        bus_if.sample_in    = 16'h4000;
        bus_if.sample_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_if.sample_valid = 1'b0;
        repeat (29) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_ready", bus_if.ready, 1);
        chk("midrst_y_valid", bus_if.y_valid, 0);
        chk("midrst_y_out", bus_if.y_out, 0);
        chk("midrst_coef_addr", bus_if.coef_addr, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        clear_hist();
        nv = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus_if.y_valid) nv++;
        end
        chk("midrst_no_y_valid", nv, 0);
        chk("midrst_ready_after", bus_if.ready, 1);

        for (int k = 0; k < NTAPS; k++) begin
            send((k == 0) ? 16'h2000 : 16'h0000, 0, y);
            imp[k] = y;
            chk($sformatf("reimp%0d", k), y, team_tab[k]);
        end
        chk("reimpulse_out2", imp[1], 16'h000D);
        chk("reimpulse_out33", imp[32], 16'h10E0);
        chk("reimpulse_out34", imp[33], 16'h0EF7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pulse_shape_fir.md
PULSE_SHAPE_FIR -- requirements
Module: pulse_shape_fir

Interface
REQ-001 SHALL have parameter NTAPS, default 65; number of filter taps.
REQ-002 SHALL have parameter DW, default 16; sample, coefficient and output width, Q2.13 signed two's complement.
REQ-003 SHALL have parameter ACCW, default 40; accumulator width.
REQ-004 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port sample_in  input  DW  symbol-mapped input sample, Q2.13.
REQ-007 SHALL have port sample_valid  input  1  sample_in valid this cycle.
REQ-008 SHALL have port ready  output  1  block can accept a sample.
REQ-009 SHALL have port coef_addr  output  7  tap index 0..NTAPS-1 requested from the coefficient source.
REQ-010 SHALL have port coef_in  input  DW  coefficient for coef_addr, valid in the same cycle (combinational source).
REQ-011 SHALL have port y_out  output  DW  filtered sample, Q2.13.
REQ-012 SHALL have port y_valid  output  1  one-cycle pulse, y_out valid.
REQ-013 SHALL have port sample_drop  output  1  one-cycle pulse, sample_valid arrived while ready low.

Function
REQ-014 SHALL accept a sample on a rising edge where sample_valid=1 and ready=1, writing it into a circular NTAPS-entry delay line at wr_ptr.
REQ-015 SHALL wrap wr_ptr from NTAPS-1 to 0.
REQ-016 SHALL compute y[n] = sum over k=0..NTAPS-1 of coef[k]*x[n-k], with x[n] the sample just accepted and x[n-k] read at (wr_ptr-k) mod NTAPS.
REQ-017 SHALL use one signed DWxDW multiplier, time-multiplexed one tap per cycle; the product SHALL be registered (Q4.26) before accumulation.
REQ-018 SHALL sign-extend products to ACCW and clear the accumulator at the start of each output computation.
REQ-019 SHALL form y_out = accumulator arithmetic-shifted right 13, rounded half-up (add 2^12 before shift), then saturated to [0x8000, 0x7FFF].
REQ-020 SHALL implement FSM IDLE -> MAC on accept; MAC -> DRAIN after tap NTAPS-1 issued; DRAIN -> OUT after the final product is accumulated; OUT -> IDLE after one cycle.
REQ-021 SHALL drive ready=1 only in IDLE.
REQ-022 SHALL assert y_valid for exactly one cycle in OUT, exactly NTAPS+2 cycles after the accepting edge (67 for default).
REQ-023 SHALL hold y_out stable from a y_valid pulse until the next y_valid pulse.
REQ-024 SHALL drive coef_addr = current tap index in MAC and 0 otherwise.
REQ-025 SHALL ignore sample_valid while ready=0 (no buffer or pointer change) and pulse sample_drop the following cycle.
REQ-026 SHALL accept back-to-back samples at a maximum rate of one per NTAPS+3 cycles.

Reset
REQ-027 SHALL, while reset_n=0, force: FSM=IDLE, ready=1, y_out=0, y_valid=0, sample_drop=0, coef_addr=0, wr_ptr=0, accumulator=0, every delay-line entry=0.
REQ-028 SHALL, on reset assertion mid-MAC/DRAIN, abandon the computation with no y_valid and resume from IDLE after release.

Structure
REQ-029 SHALL place NTAPS, DW, FRAC=13, ACCW and the FSM state encoding in shared package fir_pkg.
REQ-030 SHALL implement the delay line (write port, read-by-offset port, wrap logic) as sub-module fir_sample_line; MAC, rounding and FSM remain in pulse_shape_fir.

Verification
REQ-031 Impulse: team coefficient table on coef_in, sample 0x2000 then 64 samples 0x0000 -> successive y_out reproduce the coefficients; 2nd output=0x000D, 33rd=0x10E0, 34th=0x0EF7.
REQ-032 Rounding: coef[0]=0x1000, others 0; sample 0x0001 -> y_out=0x0001; sample 0xFFFF -> y_out=0x0000.
REQ-033 Saturation: all coefs 0x7FFF; 65 samples 0x7FFF -> final y_out=0x7FFF; 65 samples 0x8000 -> final y_out=0x8000.
REQ-034 Handshake/latency: y_valid exactly 67 cycles after accept; sample_valid pulsed at cycle 10 after accept -> sample_drop pulses once, next output unchanged from the drop-free reference model.
REQ-035 Reset mid-operation: reset_n low at cycle 30 of MAC -> no y_valid, ready=1, y_out=0; next impulse reproduces REQ-031 exactly (delay line cleared).
REQ-036 Wrap: 200 random samples vs golden model -> all y_out bit-exact across wr_ptr wrap-arounds.
